dense_layer_seq: RTL and testbench

DENSE_LAYER_SEQ -- requirements
Module: dense_layer_seq

---
 rtl/dense_layer_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_dense_layer_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_seq.sv
// Sequential dense (fully connected) layer: streams in one input vector, then computes and streams
// out one neuron at a time using a single multiplier, with bias, saturation, optional ReLU and argmax.
module dense_layer_seq #(
    parameter int IN_SIZE  = 2,
    parameter int OUT_SIZE = 3,
    parameter int WIDTH    = 18,
    parameter int FRAC     = 8,
    parameter int ACT_MODE = 1,
    localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1,
    localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_we,
    input  logic [OW-1:0]    w_row,
    input  logic [IW-1:0]    w_col,
    input  logic [WIDTH-1:0] w_data,
    input  logic             b_we,
    input  logic [OW-1:0]    b_row,
    input  logic [WIDTH-1:0] b_data,
    output logic             wr_ignored,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OW-1:0]    out_idx,
    output logic             out_last,
    output logic [OW-1:0]    out_argmax
);

    localparam int CW = $clog2(IN_SIZE + 1);
    localparam int AW = 2 * WIDTH + $clog2(IN_SIZE) + 1;
    localparam int SW = ((AW > WIDTH + FRAC) ? AW : WIDTH + FRAC) + 1;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-64'sd1 <<< (WIDTH - 1));

    typedef enum logic [1:0] {IDLE, LOAD, MAC, EMIT} state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            k_q, k_d;
    logic [CW-1:0]            i_q, i_d;
    logic [OW-1:0]            o_q, o_d;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic signed [WIDTH-1:0]  x_q [IN_SIZE];
    logic signed [WIDTH-1:0]  x_d [IN_SIZE];
    logic signed [WIDTH-1:0]  w_q [OUT_SIZE][IN_SIZE];
    logic signed [WIDTH-1:0]  w_d [OUT_SIZE][IN_SIZE];
    logic signed [WIDTH-1:0]  b_q [OUT_SIZE];
    logic signed [WIDTH-1:0]  b_d [OUT_SIZE];
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0]  out_data_q, out_data_d;
    logic [OW-1:0]            out_idx_q, out_idx_d;
    logic                     out_last_q, out_last_d;
    logic signed [WIDTH-1:0]  max_q, max_d;
    logic [OW-1:0]            argmax_q, argmax_d;
    logic                     wr_ignored_q, wr_ignored_d;

    logic [IW-1:0]            i_idx_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic signed [SW-1:0]     sum_s;
    logic signed [SW-1:0]     shr_s;
    logic signed [WIDTH-1:0]  r_s;

    // Product path and neuron finalization (bias, floor shift, saturate, activation)
    always_comb begin
        i_idx_s = '0;
        if (int'(i_q) < IN_SIZE) begin
            i_idx_s = i_q[IW-1:0];
        end else begin
            i_idx_s = '0;
        end
        prod_s = x_q[i_idx_s] * w_q[o_q][i_idx_s];
        sum_s  = SW'(acc_q) + (SW'(b_q[o_q]) <<< FRAC);
        shr_s  = sum_s >>> FRAC;
        if (shr_s > SAT_MAX) begin
            r_s = SAT_MAX[WIDTH-1:0];
        end else if (shr_s < SAT_MIN) begin
            r_s = SAT_MIN[WIDTH-1:0];
        end else begin
            r_s = shr_s[WIDTH-1:0];
        end
        if (ACT_MODE == 1 && r_s[WIDTH-1]) begin
            r_s = '0;
        end else begin
            r_s = r_s;
        end
    end

    // Next-state logic: parameter writes, input capture, MAC sequencing, output handshake
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        i_d          = i_q;
        o_d          = o_q;
        acc_d        = acc_q;
        x_d          = x_q;
        w_d          = w_q;
        b_d          = b_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_idx_d    = out_idx_q;
        out_last_d   = out_last_q;
        max_d        = max_q;
        argmax_d     = argmax_q;
        wr_ignored_d = 1'b0;

        // Out-of-range write addresses are dropped the same way as writes outside IDLE.
        if (state_q == IDLE) begin
            if (w_we) begin
                if (int'(w_row) < OUT_SIZE && int'(w_col) < IN_SIZE) begin
                    w_d[w_row][w_col] = w_data;
                end else begin
                    wr_ignored_d = 1'b1;
                end
            end else begin
                w_d = w_q;
            end
            if (b_we) begin
                if (int'(b_row) < OUT_SIZE) begin
                    b_d[b_row] = b_data;
                end else begin
                    wr_ignored_d = 1'b1;
                end
            end else begin
                b_d = b_q;
            end
        end else begin
            wr_ignored_d = w_we | b_we;
        end

        case (state_q)
            IDLE, LOAD: begin
                if (in_valid && in_ready_q) begin
                    x_d[k_q] = in_data;
                    if (int'(k_q) == IN_SIZE - 1) begin
                        state_d = MAC;
                        k_d     = '0;
                        i_d     = '0;
                        o_d     = '0;
                        acc_d   = '0;
                    end else begin
                        state_d = LOAD;
                        k_d     = k_q + IW'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            MAC: begin
                if (int'(i_q) < IN_SIZE) begin
                    acc_d = acc_q + AW'(prod_s);
                    i_d   = i_q + CW'(1);
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = r_s;
                    out_idx_d   = o_q;
                    out_last_d  = (int'(o_q) == OUT_SIZE - 1);
                    if (o_q == '0 || r_s > max_q) begin
                        max_d    = r_s;
                        argmax_d = o_q;
                    end else begin
                        max_d    = max_q;
                    end
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = IDLE;
                    end else begin
                        o_d     = o_q + OW'(1);
                        i_d     = '0;
                        acc_d   = '0;
                        state_d = MAC;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE) || (state_d == LOAD);
    end

    // State, datapath and storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            i_q          <= '0;
            o_q          <= '0;
            acc_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_idx_q    <= '0;
            out_last_q   <= 1'b0;
            max_q        <= '0;
            argmax_q     <= '0;
            wr_ignored_q <= 1'b0;
            for (int r = 0; r < OUT_SIZE; r++) begin
                b_q[r] <= '0;
                for (int c = 0; c < IN_SIZE; c++) begin
                    w_q[r][c] <= '0;
                end
            end
            for (int c = 0; c < IN_SIZE; c++) begin
                x_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            i_q          <= i_d;
            o_q          <= o_d;
            acc_q        <= acc_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
            max_q        <= max_d;
            argmax_q     <= argmax_d;
            wr_ignored_q <= wr_ignored_d;
            w_q          <= w_d;
            b_q          <= b_d;
            x_q          <= x_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_idx    = out_idx_q;
    assign out_last   = out_last_q;
    assign out_argmax = argmax_q;
    assign wr_ignored = wr_ignored_q;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Self-checking bench for dense_layer_seq: ReLU and identity instances share stimulus and are
// checked against an arithmetic reference model, with directed and randomized vectors.
module tb_dense_layer_seq;

    localparam int NI    = 2;
    localparam int NO    = 3;
    localparam int LIMIT = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        w_we, b_we, in_valid, out_ready;
    logic [1:0]  w_row, b_row;
    logic [0:0]  w_col;
    logic [17:0] w_data, b_data, in_data;

    logic        wr_ignored1, in_ready1, out_valid1, out_last1;
    logic [17:0] out_data1;
    logic [1:0]  out_idx1, out_argmax1;
    logic        wr_ignored0, in_ready0, out_valid0, out_last0;
    logic [17:0] out_data0;
    logic [1:0]  out_idx0, out_argmax0;

    int n_cmp = 0;
    int n_err = 0;
    int mw [NO][NI];
    int mb [NO];
    int mx [NI];

    always #5 clk = ~clk;

    dense_layer_seq #(.IN_SIZE(NI), .OUT_SIZE(NO), .WIDTH(18), .FRAC(8), .ACT_MODE(1)) dut_relu (
        .clk(clk), .rst_n(rst_n),
        .w_we(w_we), .w_row(w_row), .w_col(w_col), .w_data(w_data),
        .b_we(b_we), .b_row(b_row), .b_data(b_data), .wr_ignored(wr_ignored1),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_idx(out_idx1), .out_last(out_last1), .out_argmax(out_argmax1)
    );

    dense_layer_seq #(.IN_SIZE(NI), .OUT_SIZE(NO), .WIDTH(18), .FRAC(8), .ACT_MODE(0)) dut_ident (
        .clk(clk), .rst_n(rst_n),
        .w_we(w_we), .w_row(w_row), .w_col(w_col), .w_data(w_data),
        .b_we(b_we), .b_row(b_row), .b_data(b_data), .wr_ignored(wr_ignored0),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_idx(out_idx0), .out_last(out_last0), .out_argmax(out_argmax0)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference neuron: exact integer dot product, floor division by 2^8, clamp, optional ReLU.
    function automatic longint ref_neuron(input int o, input bit relu);
        longint acc, q;
        acc = 0;
        for (int i = 0; i < NI; i++) acc += longint'(mx[i]) * longint'(mw[o][i]);
        acc += longint'(mb[o]) * 256;
        q = acc / 256;
        if (acc < 0 && (acc % 256) != 0) q = q - 1;
        if (q > 131071) q = 131071;
        else if (q < -131072) q = -131072;
        if (relu && q < 0) q = 0;
        return q;
    endfunction

    function automatic int rnd_val();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 262143)) - 131072;
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic wr_w(input int r, input int c, input int v);
        logic [31:0] vv;
        vv = v;
        w_we = 1'b1; w_row = r[1:0]; w_col = c[0:0]; w_data = vv[17:0];
        @(negedge clk);
        w_we = 1'b0;
        mw[r][c] = v;
        check("wr_ignored_idle", wr_ignored1, 0);
    endtask

    task automatic wr_wb(input int r, input int c, input int wv, input int bv);
        logic [31:0] vv, bb;
        vv = wv; bb = bv;
        w_we = 1'b1; w_row = r[1:0]; w_col = c[0:0]; w_data = vv[17:0];
        b_we = 1'b1; b_row = r[1:0]; b_data = bb[17:0];
        @(negedge clk);
        w_we = 1'b0; b_we = 1'b0;
        mw[r][c] = wv;
        mb[r] = bv;
    endtask

    task automatic load_row(input int r, input int w0, input int w1, input int bv);
        wr_wb(r, 0, w0, bv);
        wr_w(r, 1, w1);
    endtask

    task automatic send_vec(input int x0, input int x1);
        logic [31:0] xv;
        int t;
        mx[0] = x0; mx[1] = x1;
        for (int e = 0; e < NI; e++) begin
            xv = (e == 0) ? x0 : x1;
            in_valid = 1'b1;
            in_data  = xv[17:0];
            t = 0;
            while (!in_ready1 && t < LIMIT) begin
                @(negedge clk);
                t++;
            end
            check("in_ready_wait", in_ready1, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int stall_o, input int stall_len, input bit chk_lat);
        longint e1, e0, best1v, best0v;
        int best1, best0, lat;
        logic [17:0] held;
        best1 = 0; best0 = 0; best1v = 0; best0v = 0;
        for (int o = 0; o < NO; o++) begin
            e1 = ref_neuron(o, 1'b1);
            e0 = ref_neuron(o, 1'b0);
            if (o == 0 || e1 > best1v) begin best1 = o; best1v = e1; end
            if (o == 0 || e0 > best0v) begin best0 = o; best0v = e0; end
            out_ready = (o == stall_o) ? 1'b0 : 1'b1;
            lat = 0;
            while (!out_valid1 && lat < LIMIT) begin
                @(negedge clk);
                lat++;
            end
            check("out_valid", out_valid1, 1);
            check("out_valid_ident", out_valid0, 1);
            if (chk_lat) check("latency", lat, 3);
            check("data_relu", $signed(out_data1), e1);
            check("data_ident", $signed(out_data0), e0);
            check("out_idx", out_idx1, o);
            check("out_last", out_last1, (o == NO - 1));
            if (o == NO - 1) begin
                check("argmax_relu", out_argmax1, best1);
                check("argmax_ident", out_argmax0, best0);
            end
            if (o == stall_o) begin
                held = out_data1;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check("stall_valid", out_valid1, 1);
                    check("stall_data", $signed(out_data1), e1);
                    check("stall_data_held", out_data1, held);
                    check("stall_idx", out_idx1, o);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("idle_in_ready", in_ready1, 1);
        check("idle_out_valid", out_valid1, 0);
    endtask

    int t0;

    initial begin
        rst_n = 1'b0; w_we = 1'b0; b_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        w_row = '0; b_row = '0; w_col = '0; w_data = '0; b_data = '0; in_data = '0;
        for (int r = 0; r < NO; r++) begin
            mb[r] = 0;
            for (int c = 0; c < NI; c++) mw[r][c] = 0;
        end
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready1, 0);
        check("rst_out_valid", out_valid1, 0);
        check("rst_out_data", out_data1, 0);
        check("rst_argmax", out_argmax1, 0);
        check("rst_wr_ignored", wr_ignored1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready1, 1);

        // Directed rows: 704 / ReLU-clamped negative / saturating product.
        load_row(0, 256, 128, 64);
        load_row(1, -256, 0, 0);
        load_row(2, 102400, 0, 0);
        send_vec(512, 256);
        collect(-1, 0, 1'b1);
        send_vec(384, 0);
        collect(-1, 0, 1'b1);
        send_vec(102400, 0);
        collect(-1, 0, 1'b1);

        // Backpressure on the first two neurons.
        send_vec(512, 256);
        collect(0, 5, 1'b1);
        send_vec(512, 256);
        collect(1, 5, 1'b1);

        // Writes outside IDLE must be dropped with a one-cycle flag.
        send_vec(512, 256);
        w_we = 1'b1; w_row = 2'd0; w_col = 1'b0; w_data = 18'd999;
        b_we = 1'b1; b_row = 2'd0; b_data = 18'd5;
        @(negedge clk);
        w_we = 1'b0; b_we = 1'b0;
        check("wr_ignored_pulse", wr_ignored1, 1);
        @(negedge clk);
        check("wr_ignored_clear", wr_ignored1, 0);
        collect(-1, 0, 1'b0);

        // Randomized weights, biases, inputs and stalls.
        for (int v = 0; v < 10; v++) begin
            for (int r = 0; r < NO; r++) load_row(r, rnd_val(), rnd_val(), rnd_val());
            send_vec(rnd_val(), rnd_val());
            collect(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 1'b1);
        end

        // Reset in the middle of neuron 1.
        load_row(0, 256, 128, 64);
        load_row(1, -256, 0, 0);
        load_row(2, 102400, 0, 0);
        send_vec(512, 256);
        out_ready = 1'b1;
        t0 = 0;
        while (!out_valid1 && t0 < LIMIT) begin
            @(negedge clk);
            t0++;
        end
        check("pre_rst_valid", out_valid1, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid1, 0);
        check("midrst_out_data", out_data1, 0);
        check("midrst_out_idx", out_idx1, 0);
        check("midrst_in_ready", in_ready1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < NO; r++) begin
            mb[r] = 0;
            for (int c = 0; c < NI; c++) mw[r][c] = 0;
        end
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            check("midrst_no_beat", out_valid1, 0);
        end
        check("midrst_ready", in_ready1, 1);
        send_vec(512, 256);
        collect(-1, 0, 1'b1);
        load_row(0, 256, 128, 64);
        send_vec(512, 256);
        collect(-1, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
